// File: rtl/fifo_vc_pkg.sv
// Shared constants and bus-width helpers for the virtual-channel FIFO array.
package fifo_vc_pkg;

  // Default geometry: 6-bit entries, 16 entries per VC, two VCs.
  localparam int unsigned DefDataSize = 6;
  localparam int unsigned DefAddrSize = 4;
  localparam int unsigned DefNumVc    = 2;

  // Width of a bus carrying one data entry per VC.
  function automatic int unsigned data_bus_w(input int unsigned data_size,
                                             input int unsigned num_vc);
    return data_size * num_vc;
  endfunction

  // Width of a bus carrying one occupancy count per VC. A count needs one
  // more bit than a pointer so that it can represent a full queue.
  function automatic int unsigned cnt_bus_w(input int unsigned addr_size,
                                            input int unsigned num_vc);
    return (addr_size + 1) * num_vc;
  endfunction

endpackage

// File: rtl/vc_fifo_ram.sv
// Per-VC storage: synchronous write, asynchronous read, contents not reset.
module vc_fifo_ram #(
  parameter int unsigned DataW = 6,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  // Write port; a read of the same address this cycle still sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_vc_array.sv
// Array of independent per-VC FIFOs with registered pop data, threshold flags,
// a hysteresis pause flag and a sticky error flag per VC.
module fifo_vc_array
  import fifo_vc_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned ADDR_SIZE = DefAddrSize,
  parameter int unsigned NUM_VC    = DefNumVc
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_VC-1:0]                         push,
  input  logic [NUM_VC-1:0]                         pop,
  input  logic [data_bus_w(DATA_SIZE, NUM_VC)-1:0]  data_in,
  input  logic [ADDR_SIZE:0]                        af_thr,
  input  logic [ADDR_SIZE:0]                        ae_thr,
  input  logic [NUM_VC-1:0]                         err_clr,
  output logic [data_bus_w(DATA_SIZE, NUM_VC)-1:0]  data_out,
  output logic [NUM_VC-1:0]                         valid_out,
  output logic [cnt_bus_w(ADDR_SIZE, NUM_VC)-1:0]   count,
  output logic [NUM_VC-1:0]                         empty,
  output logic [NUM_VC-1:0]                         full,
  output logic [NUM_VC-1:0]                         almost_full,
  output logic [NUM_VC-1:0]                         almost_empty,
  output logic [NUM_VC-1:0]                         pause,
  output logic [NUM_VC-1:0]                         error
);

  localparam int unsigned CntW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] Depth = {1'b1, {ADDR_SIZE{1'b0}}};

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic [DATA_SIZE-1:0] wr_data, rd_data;
    logic                 valid_q, valid_d;
    logic                 pause_q, pause_d;
    logic                 err_q, err_d;
    logic                 is_empty, is_full;
    logic                 pop_acc, push_acc, ram_we;

    assign wr_data = data_in[i*DATA_SIZE +: DATA_SIZE];

    // Status flags decode from the registered count only.
    always_comb begin
      is_empty = (cnt_q == '0);
      is_full  = (cnt_q == Depth);
      pop_acc  = pop[i] & ~is_empty;
      // A full queue still takes a push when a pop frees a slot in the same cycle.
      push_acc = push[i] & (~is_full | pop_acc);
      ram_we   = push_acc & ~reset;
    end

    vc_fifo_ram #(
      .DataW (DATA_SIZE),
      .AddrW (ADDR_SIZE)
    ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
    );

    // Next-state for pointers, count, read data and the pause/error flags.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      valid_d  = pop_acc;
      pause_d  = pause_q;
      err_d    = err_q;

      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = rd_data;
      end

      unique case ({push_acc, pop_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase

      // Set threshold has priority over clear threshold.
      if (cnt_d >= af_thr) begin
        pause_d = 1'b1;
      end else if (cnt_d <= ae_thr) begin
        pause_d = 1'b0;
      end

      // A new error in the same cycle beats the clear request.
      if ((push[i] & ~push_acc) | (pop[i] & is_empty)) begin
        err_d = 1'b1;
      end else if (err_clr[i]) begin
        err_d = 1'b0;
      end
    end

    // State register with synchronous reset; memory is intentionally not reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        dout_q   <= '0;
        valid_q  <= 1'b0;
        pause_q  <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        dout_q   <= dout_d;
        valid_q  <= valid_d;
        pause_q  <= pause_d;
        err_q    <= err_d;
      end
    end

    assign data_out[i*DATA_SIZE +: DATA_SIZE] = dout_q;
    assign count[i*CntW +: CntW]              = cnt_q;
    assign valid_out[i]                       = valid_q;
    assign empty[i]                           = is_empty;
    assign full[i]                            = is_full;
    assign almost_full[i]                     = (cnt_q >= af_thr);
    assign almost_empty[i]                    = (cnt_q <= ae_thr) && !is_empty;
    assign pause[i]                           = pause_q;
    assign error[i]                           = err_q;
  end

endmodule

// File: tb/tb_fifo_vc_array.sv
// Directed, self-checking bench for fifo_vc_array (default geometry: 6-bit data,
// 16 entries per VC, 2 VCs).
module tb_fifo_vc_array;

  logic        clk;
  logic        reset;
  logic [1:0]  push, pop, err_clr;
  logic [11:0] data_in;
  logic [4:0]  af_thr, ae_thr;
  logic [11:0] data_out;
  logic [1:0]  valid_out;
  logic [9:0]  count;
  logic [1:0]  empty, full, almost_full, almost_empty, pause, error;

  int total = 0;
  int bad   = 0;

  fifo_vc_array dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] push;
    logic [1:0] pop;
    logic [5:0] d0;
    logic [4:0] exp_cnt0;
    logic       exp_pause0;
    logic       exp_ae0;
    logic       exp_valid0;
    logic [5:0] exp_dout0;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic [1:0] p, input logic [1:0] q, input logic [5:0] d0,
                      input logic [5:0] d1, input logic [1:0] clr);
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = {d1, d0};
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [1:0] p, input logic [1:0] q, input logic [5:0] d0,
                         input logic [4:0] c, input logic ps, input logic ae,
                         input logic v, input logic [5:0] dout);
    vec_t r;
    r.push = p; r.pop = q; r.d0 = d0; r.exp_cnt0 = c; r.exp_pause0 = ps;
    r.exp_ae0 = ae; r.exp_valid0 = v; r.exp_dout0 = dout;
    vecs.push_back(r);
  endtask

  logic [5:0] exp_vc1 [16];

  initial begin
    // Pause-hysteresis table (af_thr=12, ae_thr=3): fill to 12, drain to 0.
    for (int k = 1; k <= 12; k++)
      add_vec(2'b01, 2'b00, 6'(8'h10 + k), 5'(k), (k >= 12), (k <= 3), 1'b0, 6'h0);
    for (int j = 1; j <= 12; j++)
      add_vec(2'b00, 2'b01, 6'h0, 5'(12 - j), ((12 - j) >= 4), ((12 - j) <= 3 && j != 12),
              1'b1, 6'(8'h10 + j));

    reset = 1'b1; push = '0; pop = '0; err_clr = '0; data_in = '0;
    af_thr = 5'd0; ae_thr = 5'd0;

    // Reset state; af_thr=0 makes almost_full true even while empty.
    step(2'b11, 2'b11, 6'h15, 6'h2A, 2'b00);
    chk("rst_count", count, 10'd0);
    chk("rst_empty", empty, 2'b11);
    chk("rst_full", full, 2'b00);
    chk("rst_aempty", almost_empty, 2'b00);
    chk("rst_afull_thr0", almost_full, 2'b11);
    chk("rst_valid", valid_out, 2'b00);
    chk("rst_pause", pause, 2'b00);
    chk("rst_error", error, 2'b00);
    chk("rst_dout", data_out, 12'h0);

    af_thr = 5'd16; ae_thr = 5'd0; reset = 1'b0;

    // Fill VC0 to full with 0x01..0x10, then overflow once.
    for (int k = 1; k <= 16; k++) step(2'b01, 2'b00, 6'(k), 6'h0, 2'b00);
    chk("fill_count0", count[4:0], 5'd16);
    chk("fill_full", full, 2'b01);
    chk("fill_afull0", almost_full[0], 1'b1);
    chk("fill_error_pre", error, 2'b00);
    step(2'b01, 2'b00, 6'h3F, 6'h0, 2'b00);
    chk("ovf_error", error, 2'b01);
    chk("ovf_count0", count[4:0], 5'd16);
    chk("ovf_count1", count[9:5], 5'd0);
    step(2'b00, 2'b00, 6'h0, 6'h0, 2'b01);
    chk("clr_error", error, 2'b00);

    // Drain VC0: order and one-cycle latency; the overflow word must not appear.
    for (int k = 1; k <= 16; k++) begin
      step(2'b00, 2'b01, 6'h0, 6'h0, 2'b00);
      chk("drain_valid", valid_out, 2'b01);
      chk("drain_data", data_out[5:0], 6'(k));
      chk("drain_count", count[4:0], 5'(16 - k));
    end
    step(2'b00, 2'b00, 6'h0, 6'h0, 2'b00);
    chk("idle_valid", valid_out, 2'b00);
    chk("idle_hold_data", data_out[5:0], 6'h10);
    chk("idle_empty", empty, 2'b11);
    step(2'b00, 2'b01, 6'h0, 6'h0, 2'b00);
    chk("udf_error", error, 2'b01);
    chk("udf_valid", valid_out, 2'b00);
    chk("udf_count", count[4:0], 5'd0);
    // Clear and a fresh underflow together: the set must win.
    step(2'b00, 2'b01, 6'h0, 6'h0, 2'b01);
    chk("set_beats_clr", error, 2'b01);
    step(2'b00, 2'b00, 6'h0, 6'h0, 2'b01);
    chk("clr_error2", error, 2'b00);

    // Table-driven pause hysteresis run.
    af_thr = 5'd12; ae_thr = 5'd3;
    foreach (vecs[n]) begin
      step(vecs[n].push, vecs[n].pop, vecs[n].d0, 6'h0, 2'b00);
      chk("tab_count0", count[4:0], vecs[n].exp_cnt0);
      chk("tab_pause0", pause[0], vecs[n].exp_pause0);
      chk("tab_aempty0", almost_empty[0], vecs[n].exp_ae0);
      chk("tab_valid0", valid_out[0], vecs[n].exp_valid0);
      if (vecs[n].exp_valid0) chk("tab_dout0", data_out[5:0], vecs[n].exp_dout0);
    end

    // VC1 full, then push+pop in the same cycle.
    for (int k = 0; k < 16; k++) step(2'b10, 2'b00, 6'h0, 6'(8'h20 + k), 2'b00);
    chk("vc1_full", full, 2'b10);
    step(2'b10, 2'b10, 6'h0, 6'h2A, 2'b00);
    chk("pp_valid", valid_out, 2'b10);
    chk("pp_data", data_out[11:6], 6'h20);
    chk("pp_count1", count[9:5], 5'd16);
    chk("pp_error", error, 2'b00);
    for (int k = 0; k < 15; k++) exp_vc1[k] = 6'(8'h21 + k);
    exp_vc1[15] = 6'h2A;
    for (int k = 0; k < 16; k++) begin
      step(2'b00, 2'b10, 6'h0, 6'h0, 2'b00);
      chk("pp_drain", data_out[11:6], exp_vc1[k]);
    end
    chk("pp_vc0_empty", empty[0], 1'b1);
    chk("pp_vc0_error", error[0], 1'b0);

    // Isolation: VC0 at 5, VC1 at 9; VC1-only pushes leave VC0 untouched.
    for (int k = 1; k <= 5; k++) step(2'b11, 2'b00, 6'(k), 6'(k), 2'b00);
    for (int k = 6; k <= 9; k++) step(2'b10, 2'b00, 6'h0, 6'(k), 2'b00);
    chk("iso_count", count, {5'd9, 5'd5});
    chk("iso_vc0_empty", empty[0], 1'b0);
    chk("iso_vc0_aempty", almost_empty[0], 1'b0);
    chk("iso_vc0_afull", almost_full[0], 1'b0);
    chk("iso_vc0_pause", pause[0], 1'b0);

    // Mid-operation reset with push/pop asserted: everything discarded.
    reset = 1'b1;
    step(2'b11, 2'b11, 6'h3F, 6'h3F, 2'b00);
    reset = 1'b0;
    chk("mrst_count", count, 10'd0);
    chk("mrst_empty", empty, 2'b11);
    chk("mrst_error", error, 2'b00);
    chk("mrst_valid", valid_out, 2'b00);
    chk("mrst_dout", data_out, 12'h0);
    step(2'b00, 2'b00, 6'h0, 6'h0, 2'b00);
    chk("post_rst_empty", empty, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
